// File: rtl/cpu_controller_if.sv
// Bus between the sequencer and its neighbours: fetch unit strobes,
// register-file read/write controls, ALU selects and status.
interface cpu_controller_if #(
    parameter int PC_W  = 5,
    parameter int CNT_W = 16
);
    // Strobe semantics: the fetch unit advances its PC on every cycle with
    // control=1 and redirects to jump_addr when pc_jump=1 in that same cycle.
    // The fetched word is valid on instruction during the following cycle.
    // Register-file read data is combinational from rf_ra1/rf_ra2.
    // rf_we is a single-cycle write qualifier for rf_wa.
    logic             run;
    logic [31:0]      instruction;
    logic [31:0]      rf_rd1;
    logic [31:0]      rf_rd2;
    logic             control;
    logic             pc_jump;
    logic [PC_W-1:0]  jump_addr;
    logic [4:0]       rf_ra1;
    logic [4:0]       rf_ra2;
    logic             rf_we;
    logic [4:0]       rf_wa;
    logic [1:0]       alu_op;
    logic             alu_src_imm;
    logic [15:0]      imm;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instruction, rf_rd1, rf_rd2,
        output control, pc_jump, jump_addr, rf_ra1, rf_ra2, rf_we, rf_wa,
               alu_op, alu_src_imm, imm, busy, halted, illegal, retired
    );

    modport slave (
        output run, instruction, rf_rd1, rf_rd2,
        input  control, pc_jump, jump_addr, rf_ra1, rf_ra2, rf_we, rf_wa,
               alu_op, alu_src_imm, imm, busy, halted, illegal, retired
    );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle sequencer: fetch strobe, decode, register writeback control
// and J/BEQ redirect for the 32-bit, 5-bit-PC processor.
module cpu_controller #(
    parameter int PC_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    cpu_controller_if.master bus,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_WB       = 3'd3,
        S_REDIRECT = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nx;
    state_t           boundary;
    logic [PC_W-1:0]  target_q;
    logic [4:0]       wa_q;
    logic [1:0]       alu_sel_q;
    logic             src_imm_q;
    logic [15:0]      imm_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    logic [2:0] op;
    logic       is_zero;
    logic       is_j;
    logic       is_beq;
    logic       is_alu;
    logic       is_illegal;
    logic       beq_taken;
    logic [4:0] dec_wa;
    logic [1:0] dec_alu_sel;
    logic       dec_src_imm;

    assign op = bus.instruction[31:29];

    always_comb begin
        is_zero     = (bus.instruction == 32'd0);
        is_j        = 1'b0;
        is_beq      = 1'b0;
        is_alu      = 1'b0;
        is_illegal  = 1'b0;
        dec_wa      = bus.instruction[23:19];
        dec_alu_sel = 2'b00;
        dec_src_imm = 1'b0;
        case (op)
            3'b000: is_j = 1'b1;
            3'b001: is_beq = 1'b1;
            3'b010: begin
                is_alu = 1'b1;
                dec_wa = bus.instruction[18:14];
            end
            3'b100: begin
                is_alu      = 1'b1;
                dec_wa      = bus.instruction[18:14];
                dec_alu_sel = 2'b10;
            end
            3'b110: begin
                is_alu      = 1'b1;
                dec_src_imm = 1'b1;
            end
            3'b111: begin
                is_alu      = 1'b1;
                dec_alu_sel = 2'b01;
                dec_src_imm = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
        beq_taken = is_beq && (bus.rf_rd1 == bus.rf_rd2);
    end

    assign boundary = bus.run ? S_FETCH : S_IDLE;

    always_comb begin
        state_nx        = state;
        retire          = 1'b0;
        bus.control     = 1'b0;
        bus.pc_jump     = 1'b0;
        bus.jump_addr   = '0;
        bus.rf_ra1      = 5'd0;
        bus.rf_ra2      = 5'd0;
        bus.rf_we       = 1'b0;
        bus.rf_wa       = 5'd0;
        bus.alu_op      = 2'b00;
        bus.alu_src_imm = 1'b0;
        bus.imm         = 16'd0;
        bus.busy        = 1'b0;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.run) state_nx = S_FETCH;
            end
            S_FETCH: begin
                bus.busy    = 1'b1;
                bus.control = 1'b1;
                state_nx    = S_DECODE;
            end
            S_DECODE: begin
                bus.busy   = 1'b1;
                bus.rf_ra1 = bus.instruction[28:24];
                bus.rf_ra2 = bus.instruction[23:19];
                if (is_zero) begin
                    state_nx = S_HALT;
                end else if (is_alu) begin
                    state_nx = S_WB;
                end else if (is_j || beq_taken) begin
                    state_nx = S_REDIRECT;
                end else begin
                    // Not-taken BEQ retires here; illegal words only flag.
                    bus.illegal = is_illegal;
                    retire      = is_beq;
                    state_nx    = boundary;
                end
            end
            S_WB: begin
                bus.busy        = 1'b1;
                bus.rf_wa       = wa_q;
                bus.rf_we       = (wa_q != 5'd0);
                bus.alu_op      = alu_sel_q;
                bus.alu_src_imm = src_imm_q;
                bus.imm         = imm_q;
                retire          = 1'b1;
                state_nx        = boundary;
            end
            S_REDIRECT: begin
                bus.busy      = 1'b1;
                bus.control   = 1'b1;
                bus.pc_jump   = 1'b1;
                bus.jump_addr = target_q;
                retire        = 1'b1;
                state_nx      = boundary;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            target_q  <= '0;
            wa_q      <= 5'd0;
            alu_sel_q <= 2'b00;
            src_imm_q <= 1'b0;
            imm_q     <= 16'd0;
            retired_q <= '0;
        end else begin
            state <= state_nx;
            if (retire) retired_q <= retired_q + 1'b1;
            // Latch everything WB/REDIRECT need so the fetch bus may change.
            if (state == S_DECODE) begin
                target_q  <= bus.instruction[PC_W-1:0];
                wa_q      <= dec_wa;
                alu_sel_q <= dec_alu_sel;
                src_imm_q <= dec_src_imm;
                imm_q     <= bus.instruction[15:0];
            end
        end
    end

    assign bus.retired = retired_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_cpu_controller.sv
// Randomized and directed bench for cpu_controller with a fetch-unit and
// register-file model plus an event scoreboard.
module tb_cpu_controller;
    localparam int PC_W  = 5;
    localparam int CNT_W = 4;
    localparam int EW    = 26;

    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    cpu_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    cpu_controller #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int m_ret;
    logic [31:0]   regs [32];
    logic [31:0]   prog_q [$];
    logic [EW-1:0] exp_q [$];
    logic          fetch_pend;
    logic          prev_ctl;
    logic          prev_jmp;

    assign bus.rf_rd1 = regs[bus.rf_ra1];
    assign bus.rf_rd2 = regs[bus.rf_ra2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each fetched word must produce on the bus.
    task automatic model_push(input logic [31:0] w);
        logic [4:0] rs, rt, rd;
        rs = w[28:24];
        rt = w[23:19];
        rd = w[18:14];
        if (w != 32'd0) begin
            case (w[31:29])
                3'd0: begin exp_q.push_back({2'd2, w[4:0], 19'd0}); m_ret = (m_ret + 1) % 16; end
                3'd1: begin
                    if (regs[rs] == regs[rt]) exp_q.push_back({2'd2, w[4:0], 19'd0});
                    m_ret = (m_ret + 1) % 16;
                end
                3'd2: begin if (rd != 0) exp_q.push_back({2'd1, rd, 2'd0, 1'b0, w[15:0]}); m_ret = (m_ret + 1) % 16; end
                3'd4: begin if (rd != 0) exp_q.push_back({2'd1, rd, 2'd2, 1'b0, w[15:0]}); m_ret = (m_ret + 1) % 16; end
                3'd6: begin if (rt != 0) exp_q.push_back({2'd1, rt, 2'd0, 1'b1, w[15:0]}); m_ret = (m_ret + 1) % 16; end
                3'd7: begin if (rt != 0) exp_q.push_back({2'd1, rt, 2'd1, 1'b1, w[15:0]}); m_ret = (m_ret + 1) % 16; end
                default: exp_q.push_back({2'd3, 24'd0});
            endcase
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == 32'd0) w = 32'd1;
        return w;
    endfunction

    task automatic check_evt(input logic [EW-1:0] got);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got 0x%0h, expected none at %0t", got, $time);
        end else begin
            chk("event", 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    // Fetch-unit model: deliver a word after each plain strobe, garbage otherwise.
    always @(posedge clk) begin
        logic [31:0] w;
        #1;
        if (fetch_pend) begin
            fetch_pend = 1'b0;
            w = (prog_q.size() != 0) ? prog_q.pop_front() : rand_word();
            bus.instruction = w;
            model_push(w);
        end else begin
            bus.instruction = $urandom();
        end
    end

    // Monitor: compare every visible effect against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rf_we) check_evt({2'd1, bus.rf_wa, bus.alu_op, bus.alu_src_imm, bus.imm});
            if (bus.control && bus.pc_jump) check_evt({2'd2, bus.jump_addr, 19'd0});
            if (bus.illegal) check_evt({2'd3, 24'd0});
            if (bus.control) chk("no_back_to_back_strobe", 32'(prev_ctl && !prev_jmp), 32'd0);
            if (bus.control && !bus.pc_jump) fetch_pend = 1'b1;
        end
        prev_ctl = bus.control;
        prev_jmp = bus.pc_jump;
    end

    task automatic clear_model();
        exp_q.delete();
        prog_q.delete();
        m_ret      = 0;
        fetch_pend = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        clear_model();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((bus.busy || bus.control) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_ret = 0;
        fetch_pend = 1'b0;
        prev_ctl = 1'b0;
        prev_jmp = 1'b0;
        bus.run = 1'b0;
        bus.instruction = 32'd0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_control", 32'(bus.control), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_state_idle", 32'(dbg_state), 32'd0);
        clear_model();
        reset = 1'b0;

        // ADDI r10,r0,10
        prog_q.push_back((32'd6 << 29) | (32'd10 << 19) | 32'd10);
        bus.run = 1'b1;
        @(negedge clk);
        chk("addi_fetch_control", 32'(bus.control), 32'd1);
        chk("addi_fetch_pc_jump", 32'(bus.pc_jump), 32'd0);
        bus.run = 1'b0;
        @(negedge clk);
        chk("addi_decode_ra1", 32'(bus.rf_ra1), 32'd0);
        chk("addi_decode_control", 32'(bus.control), 32'd0);
        @(negedge clk);
        chk("addi_wb_we", 32'(bus.rf_we), 32'd1);
        chk("addi_wb_wa", 32'(bus.rf_wa), 32'd10);
        chk("addi_wb_imm", 32'(bus.imm), 32'd10);
        chk("addi_wb_src_imm", 32'(bus.alu_src_imm), 32'd1);
        chk("addi_wb_alu_op", 32'(bus.alu_op), 32'd0);
        @(negedge clk);
        chk("addi_retired", 32'(bus.retired), 32'd1);
        chk("addi_idle_busy", 32'(bus.busy), 32'd0);

        // J 12 followed by ADDI r1,r0,3
        prog_q.push_back(32'd12);
        prog_q.push_back((32'd6 << 29) | (32'd1 << 19) | 32'd3);
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("j_decode_control", 32'(bus.control), 32'd0);
        @(negedge clk);
        chk("j_redirect_control", 32'(bus.control), 32'd1);
        chk("j_redirect_pc_jump", 32'(bus.pc_jump), 32'd1);
        chk("j_redirect_addr", 32'(bus.jump_addr), 32'd12);
        chk("j_redirect_no_we", 32'(bus.rf_we), 32'd0);
        @(negedge clk);
        chk("j_refetch_control", 32'(bus.control), 32'd1);
        chk("j_refetch_pc_jump", 32'(bus.pc_jump), 32'd0);
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        chk("j_retired", 32'(bus.retired), 32'd3);

        // BEQ r4,r5,7 not taken, then taken
        regs[4] = 32'd4;
        regs[5] = 32'd0;
        prog_q.push_back((32'd1 << 29) | (32'd4 << 24) | (32'd5 << 19) | 32'd7);
        prog_q.push_back((32'd1 << 29) | (32'd4 << 24) | (32'd5 << 19) | 32'd7);
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("beq_nt_fetch_control", 32'(bus.control), 32'd1);
        chk("beq_nt_fetch_pc_jump", 32'(bus.pc_jump), 32'd0);
        regs[5] = 32'd4;
        bus.run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("beq_t_pc_jump", 32'(bus.pc_jump), 32'd1);
        chk("beq_t_addr", 32'(bus.jump_addr), 32'd7);
        @(negedge clk);
        chk("beq_t_idle_control", 32'(bus.control), 32'd0);
        chk("beq_retired", 32'(bus.retired), 32'd5);

        // ADDI r0,r0,5: write suppressed, still retires
        prog_q.push_back((32'd6 << 29) | 32'd5);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r0_wb_we", 32'(bus.rf_we), 32'd0);
        chk("r0_wb_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("r0_retired", 32'(bus.retired), 32'd6);

        // Illegal opcode 011
        prog_q.push_back((32'd3 << 29) | (32'd1 << 14));
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        chk("illegal_pulse", 32'(bus.illegal), 32'd1);
        @(negedge clk);
        chk("illegal_one_cycle", 32'(bus.illegal), 32'd0);
        chk("illegal_no_we", 32'(bus.rf_we), 32'd0);
        chk("illegal_retired", 32'(bus.retired), 32'd6);

        // Drop run in DECODE of ADD r3=r1+r2
        prog_q.push_back((32'd2 << 29) | (32'd1 << 24) | (32'd2 << 19) | (32'd3 << 14));
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        chk("drop_wb_we", 32'(bus.rf_we), 32'd1);
        chk("drop_wb_wa", 32'(bus.rf_wa), 32'd3);
        @(negedge clk);
        chk("drop_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("drop_idle_control", 32'(bus.control), 32'd0);
        chk("drop_retired", 32'(bus.retired), 32'd7);

        // Reset during WB of SHIFTL r7=r1<<r2
        prog_q.push_back((32'd4 << 29) | (32'd1 << 24) | (32'd2 << 19) | (32'd7 << 14));
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("shl_wb_alu_op", 32'(bus.alu_op), 32'd2);
        do_reset();
        chk("wb_reset_we", 32'(bus.rf_we), 32'd0);
        chk("wb_reset_state_idle", 32'(dbg_state), 32'd0);
        chk("wb_reset_retired", 32'(bus.retired), 32'd0);

        // HALT word with run held high
        prog_q.push_back(32'd0);
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_no_control", 32'(bus.control), 32'd0);
        end
        do_reset();
        chk("halt_reset_halted", 32'(bus.halted), 32'd0);
        chk("halt_reset_retired", 32'(bus.retired), 32'd0);
        chk("halt_reset_busy", 32'(bus.busy), 32'd0);

        // Random program; run keeps toggling, counter wraps.
        for (int i = 1; i < 32; i++) regs[i] = 32'($urandom_range(0, 3));
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.run = ($urandom_range(0, 7) != 0);
        end
        bus.run = 1'b0;
        @(negedge clk);
        wait_idle("rand_drain_idle");
        @(negedge clk);
        chk("rand_retired", 32'(bus.retired), 32'(m_ret));
        chk("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle sequencer for the 32-bit, 5-bit-PC processor. It drives the fetch strobe and jump redirect of the instruction fetch unit and decodes each fetched word. It issues register-file read/write controls and ALU op selects, and resolves J/BEQ control flow. It sits between the fetch unit (`instruction_decoder`), the register file and the ALU.

## Interface
- `PC_W`, 5, width of instruction address / jump target
- `CNT_W`, 16, width of retired-instruction counter
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high; also drives the fetch unit's reset
- `run` in 1: level; enables execution, sampled at instruction boundaries
- `instruction` in 32: word from fetch unit, valid the cycle after a `control` pulse
- `rf_rd1`, `rf_rd2` in 32: register-file read data, combinational from `rf_ra1`/`rf_ra2`
- `control` out 1: fetch strobe to fetch unit
- `pc_jump` out 1: redirect request, qualified by `control`
- `jump_addr` out PC_W: redirect target
- `rf_ra1`, `rf_ra2` out 5: read addresses = instruction[28:24], instruction[23:19]
- `rf_we` out 1, `rf_wa` out 5: register write enable/address
- `alu_op` out 2: 00 ADD, 01 SUB, 10 SHL
- `alu_src_imm` out 1: ALU operand B = `imm` instead of `rf_rd2`
- `imm` out 16: instruction[15:0], zero-extended by the ALU
- `busy` out 1, `halted` out 1, `illegal` out 1 (one-cycle pulse), `retired` out CNT_W

## Operation
- Field map: op=[31:29], rs=[28:24], rt=[23:19], rd=[18:14], imm=[15:0].
- Opcodes:
  - 000 J: target = [4:0].
  - 001 BEQ: if rs==rt, target = imm[4:0].
  - 010 ADD: rd = rs + rt.
  - 100 SHIFTL: rd = rs << rt.
  - 110 ADDI: rt = rs + imm.
  - 111 SUBI: rt = rs − imm.
  - 011 and 101 are illegal.
- The all-zero word is HALT. It takes precedence over J.
- The fetch unit advances its PC on every `control` pulse. A redirect therefore costs one extra strobe carrying `pc_jump`=1. The word fetched by that strobe is discarded.
- FSM states: IDLE, FETCH, DECODE, WB, REDIRECT, HALT.
  - IDLE: all strobes 0, `busy`=0. Goes to FETCH when `run`=1.
  - FETCH: `control`=1, `pc_jump`=0. Goes to DECODE.
  - DECODE: `rf_ra1`/`rf_ra2` driven from `instruction`. Next state by instruction class:
    - zero word → HALT.
    - ALU op → WB.
    - J → REDIRECT.
    - BEQ with `rf_rd1`==`rf_rd2` → REDIRECT.
    - BEQ not taken → boundary.
    - illegal → `illegal`=1 for this cycle, then boundary.
  - WB: `rf_we`=1, `rf_wa`=rd (R-type) or rt (I-type), `alu_op`/`alu_src_imm` per opcode. `rf_we` is forced 0 when `rf_wa`==0. Goes to boundary.
  - REDIRECT: `control`=1, `pc_jump`=1, `jump_addr`=latched target. Goes to boundary.
  - Boundary: FETCH if `run`=1, else IDLE.
  - HALT: `halted`=1, no strobes. Only `reset` exits.
- `retired` increments by 1 on leaving WB, REDIRECT, or not-taken BEQ DECODE. Illegal and HALT words are not counted. The counter wraps modulo 2^CNT_W.
- Target and op fields are latched in DECODE, so outputs in WB/REDIRECT are independent of `instruction` changes.

## Timing
- Reset value of every output is 0; state is IDLE; `retired`=0.
- Reset wins over every state and any simultaneous `run`. Reset asserted mid-instruction aborts it with no write.
- ALU instruction: 3 cycles (FETCH, DECODE, WB).
- Not-taken BEQ and illegal: 2 cycles.
- J and taken BEQ: 3 cycles, plus the next FETCH.
- `run` is sampled only in IDLE and at boundaries. Dropping it mid-instruction completes the current instruction first.
- BEQ compares `rf_rd1`/`rf_rd2` in the DECODE cycle. The register file must be combinational-read.
- `control` is never asserted in two consecutive cycles except for REDIRECT→FETCH.

## Test plan
- Reset, `run`=1, word ADDI r10,r0,10:
  - next cycle: `control`=1.
  - then DECODE with `rf_ra1`=0.
  - then `rf_we`=1, `rf_wa`=10, `imm`=10, `alu_src_imm`=1, `alu_op`=00.
  - `retired`=1 after WB.
- Word J 12:
  - DECODE is followed by one cycle of `control`=1, `pc_jump`=1, `jump_addr`=12.
  - then `control`=1, `pc_jump`=0.
  - no `rf_we`; `retired` +1.
- BEQ r4,r5,7:
  - `rf_rd1`=4, `rf_rd2`=0 → no redirect, FETCH follows DECODE directly.
  - `rf_rd1`=`rf_rd2`=4 → REDIRECT with `jump_addr`=7.
- Word ADDI r0,r0,5 → WB cycle with `rf_we`=0; `retired` still increments.
- Word 0x00000000 → `halted`=1, `control` stays 0 for 20 cycles with `run`=1. `reset` returns to IDLE with `halted`=0 and `retired`=0.
- Opcode 011 → `illegal` high for exactly 1 cycle, no write, `retired` unchanged.
- Reset during WB → next cycle `rf_we`=0, state IDLE.
- Drop `run` in DECODE of an ADD → WB completes, then IDLE, then no `control`.
